ps2_kbd_ctrl: RTL and testbench

Keyboard-side sequencer behind the PS/2 frame receiver. It consumes validated 8-bit scancode bytes, resolves the E0 (extended) and F0 (break) prefix sequences into single key events, and queues the events in a small FIFO. A ready/valid interface to the bus/MMIO side drains the FIFO. A prefix watchdog and protocol-error reporting keep the decoder from wedging on lost bytes.

---
 rtl/ps2_kbd_ctrl.sv | 153 +++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scancode sequencer: folds E0/F0 prefixes into key events and queues them in a show-ahead FIFO.
// Optional typematic repeat filter enabled by defining PS2_REPEAT_FILTER_EN.
module ps2_kbd_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 1000000,
    parameter int TO_W       = 20
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_valid,
    input  logic [7:0]                    frame_data,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_release,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic                          err
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t          state, state_nx;
    logic [TO_W-1:0] wd, wd_nx;
    logic            dec_push, dec_ext, dec_rel, err_nx, push;
    logic            is_prefix;
    logic [9:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            full, pop, wr_en;

    assign is_prefix = (frame_data == 8'hE0) || (frame_data == 8'hF0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            wd    <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            wd    <= wd_nx;
            err   <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wd_nx    = wd;
        dec_push = 1'b0;
        dec_ext  = 1'b0;
        dec_rel  = 1'b0;
        err_nx   = 1'b0;
        if (frame_valid) begin
            wd_nx = '0;
            unique case (state)
                IDLE: begin
                    if (frame_data == 8'hE0)                             state_nx = EXT;
                    else if (frame_data == 8'hF0)                        state_nx = BRK;
                    else if (frame_data == 8'h00 || frame_data == 8'hFF) err_nx   = 1'b1;
                    else                                                 dec_push = 1'b1;
                end
                EXT: begin
                    if (frame_data == 8'hF0)      state_nx = EXT_BRK;
                    else if (frame_data != 8'hE0) begin
                        dec_push = 1'b1;
                        dec_ext  = 1'b1;
                        state_nx = IDLE;
                    end
                end
                BRK, EXT_BRK: begin
                    state_nx = IDLE;
                    if (is_prefix) begin
                        err_nx = 1'b1;
                    end else begin
                        dec_push = 1'b1;
                        dec_rel  = 1'b1;
                        dec_ext  = (state == EXT_BRK);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end else if (state == IDLE) begin
            wd_nx = '0;
        end else if (wd == TO_W'(TIMEOUT - 1)) begin
            // lost byte after a prefix: abandon the sequence
            state_nx = IDLE;
            err_nx   = 1'b1;
            wd_nx    = '0;
        end else begin
            wd_nx = wd + TO_W'(1);
        end
    end

`ifdef PS2_REPEAT_FILTER_EN
    logic       held_valid, held_ext, held_match;
    logic [7:0] held_code;

    assign held_match = held_valid && (held_ext == dec_ext) && (held_code == frame_data);
    assign push       = dec_push && !(!dec_rel && held_match);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_valid <= 1'b0;
            held_ext   <= 1'b0;
            held_code  <= '0;
        end else if (dec_push) begin
            if (!dec_rel) begin
                if (!held_match) begin
                    held_valid <= 1'b1;
                    held_ext   <= dec_ext;
                    held_code  <= frame_data;
                end
            end else if (held_match) begin
                held_valid <= 1'b0;
            end
        end
    end
`else
    assign push = dec_push;
`endif

    assign evt_valid = (evt_count != '0);
    assign full      = (evt_count == (AW+1)'(FIFO_DEPTH));
    assign pop       = evt_valid && evt_ready;
    assign wr_en     = push && (!full || pop);
    assign {evt_ext, evt_release, evt_code} = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= {dec_ext, dec_rel, frame_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            evt_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !pop)      evt_count <= evt_count + (AW+1)'(1);
            else if (pop && !wr_en) evt_count <= evt_count - (AW+1)'(1);
            if (push && full && !pop) overflow <= 1'b1;
            else if (clr_overflow)    overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: queue-based event model checked every cycle plus directed literal checks.
// Honours PS2_REPEAT_FILTER_EN the same way as the design.
module tb_ps2_kbd_ctrl;
    localparam int DEPTH = 8;
    localparam int TMO   = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_valid = 1'b0;
    logic [7:0] frame_data = '0;
    logic       evt_ready = 1'b0;
    logic       clr_overflow = 1'b0;
    logic       evt_valid, evt_code_ext, evt_release, overflow, err;
    logic [7:0] evt_code;
    logic [3:0] evt_count;

    ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .TO_W(5)) dut (
        .clk(clk), .reset(reset), .frame_valid(frame_valid), .frame_data(frame_data),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_ext(evt_code_ext), .evt_release(evt_release), .evt_count(evt_count),
        .overflow(overflow), .clr_overflow(clr_overflow), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending prefix flags, time of last prefix byte, event queue.
    logic [9:0]  mq[$];
    bit          m_pre, m_ext, m_brk, m_ovf, m_err;
    int unsigned cyc = 0, pre_cyc = 0;
    bit          h_v, h_ext;
    logic [7:0]  h_code;

    always @(posedge clk or negedge reset) begin : model
        logic [7:0] b;
        logic [9:0] e;
        bit have, popped, was_full, match;
        if (!reset) begin
            mq.delete();
            m_pre = 0; m_ext = 0; m_brk = 0; m_ovf = 0; m_err = 0; h_v = 0;
        end else begin
            cyc++;
            popped   = (mq.size() > 0) && evt_ready;
            was_full = (mq.size() == DEPTH);
            have = 0; m_err = 0; e = '0;
            if (frame_valid) begin
                b = frame_data;
                if (!m_pre) begin
                    if (b == 8'hE0)      begin m_pre = 1; m_ext = 1; m_brk = 0; pre_cyc = cyc; end
                    else if (b == 8'hF0) begin m_pre = 1; m_ext = 0; m_brk = 1; pre_cyc = cyc; end
                    else if (b == 8'h00 || b == 8'hFF) m_err = 1;
                    else begin have = 1; e = {2'b00, b}; end
                end else if (m_brk) begin
                    m_pre = 0;
                    if (b == 8'hE0 || b == 8'hF0) m_err = 1;
                    else begin have = 1; e = {m_ext, 1'b1, b}; end
                end else begin
                    if (b == 8'hF0)      begin m_brk = 1; pre_cyc = cyc; end
                    else if (b == 8'hE0) pre_cyc = cyc;
                    else begin have = 1; e = {2'b10, b}; m_pre = 0; end
                end
            end else if (m_pre && (cyc - pre_cyc == TMO)) begin
                m_err = 1; m_pre = 0;
            end
`ifdef PS2_REPEAT_FILTER_EN
            if (have) begin
                match = h_v && (h_ext == e[9]) && (h_code == e[7:0]);
                if (!e[8]) begin
                    if (match) have = 0;
                    else begin h_v = 1; h_ext = e[9]; h_code = e[7:0]; end
                end else if (match) h_v = 0;
            end
`endif
            if (clr_overflow) m_ovf = 0;
            if (popped) void'(mq.pop_front());
            if (have) begin
                if (!was_full || popped) mq.push_back(e);
                else m_ovf = 1;
            end
        end
    end

    logic [9:0] log_q[$];
    int err_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("evt_valid", evt_valid, mq.size() != 0);
            chk("evt_count", evt_count, mq.size());
            chk("overflow", overflow, m_ovf);
            chk("err", err, m_err);
            if (mq.size() != 0) chk("head", {evt_code_ext, evt_release, evt_code}, mq[0]);
        end
        if (reset && evt_valid && evt_ready) log_q.push_back({evt_code_ext, evt_release, evt_code});
        if (reset && err) err_cnt++;
    end

    logic [9:0] exp_q[$];

    task automatic check_log(input string name);
        chk({name, "_n"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk(name, log_q[i], exp_q[i]);
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        frame_valid = 1'b1; frame_data = b;
        @(posedge clk); #1;
        frame_valid = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        chk_en = 1'b1;
        idle(2);
        chk("rst_valid", evt_valid, 0);
        chk("rst_count", evt_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_err", err, 0);
        chk("rst_head", {evt_code_ext, evt_release, evt_code}, 0);
        reset = 1'b1;

        // make / break pair
        evt_ready = 1'b1; err_cnt = 0;
        send(8'h1C);
        chk("t1_valid_n1", evt_valid, 1);
        chk("t1_code_n1", evt_code, 8'h1C);
        send(8'hF0); send(8'h1C);
        idle(3);
        exp_q.push_back(10'h01C); exp_q.push_back(10'h11C);
        check_log("t1_log");
        chk("t1_err", err_cnt, 0);

        // extended make / break
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        idle(3);
        exp_q.push_back(10'h275); exp_q.push_back(10'h375);
        check_log("t2_log");

        // overflow, clear, drain in order
        evt_ready = 1'b0;
        for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
        idle(2);
        chk("t3_count", evt_count, 8);
        chk("t3_ovf", overflow, 1);
        clr_overflow = 1'b1; idle(1); clr_overflow = 1'b0;
        chk("t3_ovf_clr", overflow, 0);
        evt_ready = 1'b1;
        idle(10);
        for (int i = 0; i < 8; i++) exp_q.push_back(10'h010 + 10'(i));
        check_log("t3_log");

        // full with simultaneous push and pop
        evt_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
        @(posedge clk); #1;
        evt_ready = 1'b1; frame_valid = 1'b1; frame_data = 8'h28;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        chk("t3b_count", evt_count, 8);
        chk("t3b_ovf", overflow, 0);
        idle(10);
        for (int i = 0; i < 9; i++) exp_q.push_back(10'h020 + 10'(i));
        check_log("t3b_log");

        // watchdog expiry after a lone prefix
        err_cnt = 0;
        send(8'hE0);
        idle(TMO + 5);
        chk("t4_err_cnt", err_cnt, 1);
        send(8'h1C);
        idle(2);
        exp_q.push_back(10'h01C);
        check_log("t4_log");

        // protocol errors
        err_cnt = 0;
        send(8'hF0); send(8'hF0); send(8'h00);
        idle(2);
        chk("t5_err_cnt", err_cnt, 2);
        send(8'h2A);
        idle(2);
        exp_q.push_back(10'h02A);
        check_log("t5_log");

        // typematic repeats
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
        idle(3);
`ifdef PS2_REPEAT_FILTER_EN
        chk("t6_events", log_q.size(), 3);
        exp_q.push_back(10'h01C); exp_q.push_back(10'h11C); exp_q.push_back(10'h01C);
`else
        chk("t6_events", log_q.size(), 5);
        for (int i = 0; i < 3; i++) exp_q.push_back(10'h01C);
        exp_q.push_back(10'h11C); exp_q.push_back(10'h01C);
`endif
        check_log("t6_log");

        // reset mid-sequence discards queue and prefix
        evt_ready = 1'b0; err_cnt = 0;
        send(8'h30); send(8'h31); send(8'hE0);
        reset = 1'b0; #1;
        chk("t7_count", evt_count, 0);
        chk("t7_valid", evt_valid, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        evt_ready = 1'b1;
        log_q.delete();
        send(8'h1C);
        idle(TMO + 5);
        exp_q.push_back(10'h01C);
        check_log("t7_log");
        chk("t7_err_cnt", err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
